// File: rtl/axbs_pkg.sv
// axbs_pkg: shared types, AXI constants and burst sizing for the burst splitter.
package axbs_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP, ST_DONE} st_e;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  // Beats in the next burst: stop at the bl-aligned boundary or at the end of the request.
  function automatic logic [31:0] burst_len(input logic [31:0] addr_w, input logic [31:0] len_w, input logic [31:0] bl);
    logic [31:0] room;
    room = bl - (addr_w & (bl - 32'd1));
    return (room < len_w) ? room : len_w;
  endfunction
endpackage

// File: rtl/axbs_ost_cnt.sv
// axbs_ost_cnt: saturating outstanding-burst counter with full/zero flags and an underflow pulse.
module axbs_ost_cnt #(
  parameter int MAX_OST = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_zero,
  output logic o_zero_nxt,
  output logic o_underflow
);
  localparam int OW = $clog2(MAX_OST + 1);
  logic [OW-1:0] r_cnt, w_cnt_nxt;
  assign o_full = r_cnt == OW'(MAX_OST);
  assign o_zero = r_cnt == '0;
  assign o_underflow = i_dec && o_zero;
  assign o_zero_nxt = w_cnt_nxt == '0;
  always_comb w_cnt_nxt = (i_inc && !i_dec && !o_full) ? r_cnt + 1'b1 :
                          (i_dec && !i_inc && !o_zero) ? r_cnt - 1'b1 : r_cnt;
  always_ff @(posedge clk) r_cnt <= !reset_n ? '0 : w_cnt_nxt;
endmodule

// File: rtl/axburst_splitter.sv
// axburst_splitter: splits a DMA request into bl-aligned AXI INCR bursts under an outstanding limit.
// Define AXBS_TIMEOUT_EN to add the idle-cycle timeout (dma_err[3]); otherwise it is tied off.
module axburst_splitter
  import axbs_pkg::*;
#(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2,
  parameter int AXI_BRESPW = 2,
  parameter int MAX_BL     = 16,
  parameter int MAX_OST    = 4,
  parameter int TMO_W      = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   cfg_dma_valid,
  output logic                                   cfg_dma_ready,
  input  logic [31:0]                            cfg_dma_sa,
  input  logic [31:0]                            cfg_dma_len,
  input  logic [AXI_IW-1:0]                      cfg_dma_id,
  input  logic [$clog2($clog2(MAX_BL)+1)-1:0]    cfg_dma_bl,
  input  logic [TMO_W-1:0]                       cfg_dma_tmo,
  input  logic                                   dma_irq_w1c,
  output logic                                   dma_irq,
  output logic [3:0]                             dma_err,
  output logic [AXI_IW-1:0]                      axid,
  output logic [AXI_AW-1:0]                      axaddr,
  output logic [AXI_LW-1:0]                      axlen,
  output logic [AXI_SW-1:0]                      axsize,
  output logic [AXI_BURSTW-1:0]                  axburst,
  output logic                                   axvalid,
  input  logic                                   axready,
  input  logic [AXI_IW-1:0]                      usr_bid,
  input  logic [AXI_BRESPW-1:0]                  usr_bresp,
  input  logic                                   usr_bvalid,
  input  logic                                   usr_bready
);
  localparam int L      = $clog2(AXI_DW / 8);
  localparam int LOG_BL = $clog2(MAX_BL);
  localparam int BLW    = $clog2(LOG_BL + 1);
  localparam int AWW    = AXI_AW - L;
  localparam int LENW   = 32 - L;
  if (MAX_BL * (AXI_DW / 8) > 4096 || (MAX_BL & (MAX_BL - 1)) != 0 || MAX_BL > 2**AXI_LW ||
      MAX_OST < 1 || AXI_AW > 32) begin : g_cfg_err
    $error("axburst_splitter: illegal parameter combination");
  end
  st_e             r_st, w_st_nxt;
  logic [AWW-1:0]  r_addr_w;
  logic [LENW-1:0] r_len_w;
  logic [AXI_IW-1:0] r_id;
  logic [BLW-1:0]  r_bl, w_bl_clamp;
  logic [3:0]      r_err;
  logic [31:0]     w_beats;
  logic w_ax_hs, w_b_hs, w_last, w_full, w_zero, w_zero_nxt, w_underflow, w_tmo_hit, w_clr, w_unused;
  assign w_bl_clamp = (cfg_dma_bl > BLW'(LOG_BL)) ? BLW'(LOG_BL) : cfg_dma_bl;
  assign w_beats = burst_len(32'(r_addr_w), 32'(r_len_w), 32'd1 << r_bl);
  assign w_last = w_beats == 32'(r_len_w);
  assign w_ax_hs = axvalid && axready;
  assign w_b_hs = usr_bvalid && usr_bready;
  assign w_clr = (r_st == ST_DONE) && dma_irq_w1c;
  assign cfg_dma_ready = r_st == ST_IDLE;
  assign dma_irq = r_st == ST_DONE;
  assign dma_err = r_err;
  assign axvalid = (r_st == ST_BUSY) && !w_full && !w_tmo_hit;
  assign axid = r_id;
  assign axaddr = {r_addr_w, {L{1'b0}}};
  assign axlen = AXI_LW'(w_beats - 32'd1);
  assign axsize = AXI_SW'(L);
  assign axburst = AXI_BURSTW'(AXI_BURST_INCR);
  assign w_unused = ^{cfg_dma_sa, cfg_dma_len, cfg_dma_tmo, w_zero};
  axbs_ost_cnt #(.MAX_OST(MAX_OST)) u_ost (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_inc      (w_ax_hs),
    .i_dec      (w_b_hs),
    .o_full     (w_full),
    .o_zero     (w_zero),
    .o_zero_nxt (w_zero_nxt),
    .o_underflow(w_underflow)
  );
`ifdef AXBS_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic w_run;
  assign w_run = (r_st == ST_BUSY) || (r_st == ST_RESP);
  assign w_tmo_hit = w_run && (cfg_dma_tmo != '0) && (r_tmo == cfg_dma_tmo);
  always_ff @(posedge clk)
    r_tmo <= (!reset_n || !w_run || w_ax_hs || w_b_hs) ? '0 : r_tmo + 1'b1;
`else
  assign w_tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk) r_st <= !reset_n ? ST_IDLE : w_st_nxt;
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_IDLE: w_st_nxt = !cfg_dma_valid ? ST_IDLE : (cfg_dma_len[31:L] != '0) ? ST_BUSY : ST_DONE;
      ST_BUSY: w_st_nxt = w_tmo_hit ? ST_DONE : !(w_ax_hs && w_last) ? ST_BUSY : w_zero_nxt ? ST_DONE : ST_RESP;
      ST_RESP: w_st_nxt = (w_tmo_hit || w_zero_nxt) ? ST_DONE : ST_RESP;
      ST_DONE: w_st_nxt = dma_irq_w1c ? ST_IDLE : ST_DONE;
      default: w_st_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_addr_w <= '0;
      r_len_w  <= '0;
      r_id     <= '0;
      r_bl     <= '0;
    end else if (cfg_dma_valid && cfg_dma_ready) begin
      r_addr_w <= cfg_dma_sa[AXI_AW-1:L];
      r_len_w  <= cfg_dma_len[31:L];
      r_id     <= cfg_dma_id;
      r_bl     <= w_bl_clamp;
    end else if (w_ax_hs) begin
      r_addr_w <= r_addr_w + AWW'(w_beats);
      r_len_w  <= r_len_w - LENW'(w_beats);
    end
  // Error bits are sticky; only the first non-OKAY response code is kept.
  always_ff @(posedge clk)
    if (!reset_n || w_clr) r_err <= '0;
    else begin
      if (w_b_hs && usr_bresp != AXI_BRESPW'(AXI_RESP_OKAY) && r_err[1:0] == 2'b00) r_err[1:0] <= 2'(usr_bresp);
      if (w_b_hs && (usr_bid != r_id || w_underflow)) r_err[2] <= 1'b1;
      if (w_tmo_hit) r_err[3] <= 1'b1;
    end
endmodule

// File: tb/tb_axburst_splitter.sv
// tb_axburst_splitter: directed bench with a burst-queue model checked on every cycle axvalid is high.
module tb_axburst_splitter;
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
  } burst_t;
  logic clk = 1'b0;
  logic reset_n, cfg_dma_valid, cfg_dma_ready, dma_irq_w1c, dma_irq;
  logic [31:0] cfg_dma_sa, cfg_dma_len, axaddr;
  logic [7:0] cfg_dma_id, axid, axlen, usr_bid;
  logic [2:0] cfg_dma_bl, axsize;
  logic [15:0] cfg_dma_tmo;
  logic [3:0] dma_err;
  logic [1:0] axburst, usr_bresp;
  logic axvalid, axready, usr_bvalid, usr_bready;
  int n_tests = 0, n_fail = 0, n_hs = 0, ost_m = 0;
  burst_t q[$];
  always #5 clk = ~clk;
  axburst_splitter dut (
    .clk(clk), .reset_n(reset_n), .cfg_dma_valid(cfg_dma_valid), .cfg_dma_ready(cfg_dma_ready),
    .cfg_dma_sa(cfg_dma_sa), .cfg_dma_len(cfg_dma_len), .cfg_dma_id(cfg_dma_id), .cfg_dma_bl(cfg_dma_bl),
    .cfg_dma_tmo(cfg_dma_tmo), .dma_irq_w1c(dma_irq_w1c), .dma_irq(dma_irq), .dma_err(dma_err),
    .axid(axid), .axaddr(axaddr), .axlen(axlen), .axsize(axsize), .axburst(axburst), .axvalid(axvalid),
    .axready(axready), .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid), .usr_bready(usr_bready)
  );
  // Every presented burst must be the next one the model predicts, and the outstanding limit must hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      ost_m = 0;
    end else begin
      if (axvalid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL ax_unexpected got addr=%h len=%0d", axaddr, axlen);
        end else if (axaddr !== q[0].addr || axlen !== q[0].len || axid !== q[0].id || axsize !== 3'd4 || axburst !== 2'b01) begin
          n_fail++;
          $display("FAIL ax_burst got addr=%h len=%0d id=%h size=%0d burst=%0d exp addr=%h len=%0d id=%h size=4 burst=1",
                   axaddr, axlen, axid, axsize, axburst, q[0].addr, q[0].len, q[0].id);
        end
        n_tests++;
        if (ost_m >= 4) begin
          n_fail++;
          $display("FAIL ax_ost_limit axvalid=1 with outstanding=%0d exp <4", ost_m);
        end
        if (axready && q.size() > 0) begin
          void'(q.pop_front());
          ost_m++;
          n_hs++;
        end
      end
      if (usr_bvalid && usr_bready && ost_m > 0) ost_m--;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic build(input logic [31:0] sa, input logic [31:0] len, input logic [2:0] bl, input logic [7:0] id);
    int unsigned a, n, b, room, beats;
    a = sa >> 4;
    n = len >> 4;
    b = 1 << ((bl > 3'd4) ? 4 : int'(bl));
    while (n > 0) begin
      room = b - (a % b);
      beats = (room < n) ? room : n;
      q.push_back('{addr: a << 4, len: 8'(beats - 1), id: id});
      a = (a + beats) & 32'h0FFF_FFFF;
      n -= beats;
    end
  endtask
  task automatic start(input logic [31:0] sa, input logic [31:0] len, input logic [2:0] bl, input logic [7:0] id);
    chk("cfg_ready_before_req", cfg_dma_ready, 1);
    build(sa, len, bl, id);
    n_hs = 0;
    cfg_dma_sa = sa;
    cfg_dma_len = len;
    cfg_dma_bl = bl;
    cfg_dma_id = id;
    cfg_dma_valid = 1'b1;
    tick();
    cfg_dma_valid = 1'b0;
  endtask
  task automatic send_b(input logic [7:0] id, input logic [1:0] resp);
    usr_bid = id;
    usr_bresp = resp;
    usr_bvalid = 1'b1;
    usr_bready = 1'b1;
    tick();
    usr_bvalid = 1'b0;
    usr_bready = 1'b0;
  endtask
  task automatic wait_q(input string nm);
    for (int k = 0; k < 300 && q.size() > 0; k++) tick();
    chk(nm, q.size(), 0);
  endtask
  task automatic w1c();
    dma_irq_w1c = 1'b1;
    tick();
    dma_irq_w1c = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0;
    cfg_dma_valid = 1'b0;
    cfg_dma_sa = '0;
    cfg_dma_len = '0;
    cfg_dma_id = '0;
    cfg_dma_bl = '0;
    cfg_dma_tmo = '0;
    dma_irq_w1c = 1'b0;
    axready = 1'b1;
    usr_bid = '0;
    usr_bresp = '0;
    usr_bvalid = 1'b0;
    usr_bready = 1'b0;
    tick();
    tick();
    chk("rst_ready", cfg_dma_ready, 1);
    chk("rst_irq", dma_irq, 0);
    chk("rst_err", dma_err, 0);
    chk("rst_axvalid", axvalid, 0);
    reset_n = 1'b1;
    tick();
    // Unaligned start, 16-beat alignment
    start(32'h1000_0030, 32'h200, 3'd4, 8'h05);
    chk("t1_model_n", q.size(), 3);
    chk("t1_model_a0", q[0].addr, 32'h1000_0030);
    chk("t1_model_l0", q[0].len, 12);
    chk("t1_model_a1", q[1].addr, 32'h1000_0100);
    chk("t1_model_l1", q[1].len, 15);
    chk("t1_model_a2", q[2].addr, 32'h1000_0200);
    chk("t1_model_l2", q[2].len, 2);
    wait_q("t1_bursts");
    chk("t1_resp_wait_irq", dma_irq, 0);
    chk("t1_resp_wait_axvalid", axvalid, 0);
    send_b(8'h05, 2'b00);
    send_b(8'h05, 2'b00);
    chk("t1_irq_after_2", dma_irq, 0);
    send_b(8'h05, 2'b00);
    chk("t1_irq", dma_irq, 1);
    chk("t1_err", dma_err, 0);
    chk("t1_ready_in_done", cfg_dma_ready, 0);
    w1c();
    chk("t1_ready_after_w1c", cfg_dma_ready, 1);
    chk("t1_irq_after_w1c", dma_irq, 0);
    // Single-beat bursts with responses withheld: outstanding limit stalls issue
    start(32'h2000_0000, 32'h400, 3'd0, 8'h01);
    for (int k = 0; k < 6; k++) tick();
    chk("t2_hs_at_limit", n_hs, 4);
    chk("t2_axvalid_low", axvalid, 0);
    w1c();
    chk("t2_w1c_ignored", cfg_dma_ready, 0);
    send_b(8'h01, 2'b00);
    chk("t2_axvalid_back", axvalid, 1);
    chk("t2_hs_before_5th", n_hs, 4);
    tick();
    chk("t2_hs_5th", n_hs, 5);
    for (int k = 0; k < 600 && (q.size() > 0 || ost_m > 0); k++) begin
      if (ost_m > 0) send_b(8'h01, 2'b00);
      else tick();
    end
    chk("t2_drained", q.size() + ost_m, 0);
    chk("t2_irq", dma_irq, 1);
    chk("t2_err", dma_err, 0);
    w1c();
    // Sub-word length: no bursts, straight to DONE
    start(32'h0000_1000, 32'h8, 3'd2, 8'h03);
    chk("t3_irq", dma_irq, 1);
    chk("t3_axvalid", axvalid, 0);
    tick();
    chk("t3_axvalid_later", axvalid, 0);
    w1c();
    chk("t3_ready", cfg_dma_ready, 1);
    // Error capture; bl=7 clamps to 16 beats
    start(32'h3000_0000, 32'h200, 3'd7, 8'h07);
    chk("t4_model_n", q.size(), 2);
    chk("t4_model_l0", q[0].len, 15);
    wait_q("t4_bursts");
    send_b(8'h07, 2'b10);
    chk("t4_err_slverr", dma_err, 4'b0010);
    send_b(8'h08, 2'b00);
    chk("t4_err_id", dma_err, 4'b0110);
    chk("t4_irq", dma_irq, 1);
    w1c();
    chk("t4_err_clr", dma_err, 0);
    chk("t4_ready", cfg_dma_ready, 1);
`ifdef AXBS_TIMEOUT_EN
    begin
      int k;
      axready = 1'b0;
      cfg_dma_tmo = 16'd100;
      start(32'h4000_0000, 32'h100, 3'd4, 8'h09);
      for (k = 1; k <= 200 && !dma_err[3]; k++) tick();
      chk("t5_tmo_cycles_in_range", (k >= 100 && k <= 101) ? 1 : 0, 1);
      chk("t5_tmo_err", dma_err, 4'b1000);
      chk("t5_tmo_irq", dma_irq, 1);
      chk("t5_tmo_axvalid", axvalid, 0);
      q.delete();
      axready = 1'b1;
      cfg_dma_tmo = '0;
      w1c();
    end
`endif
    // Address wrap, then reset mid-operation
    start(32'hFFFF_FFF0, 32'h20, 3'd4, 8'h02);
    chk("t6_model_n", q.size(), 2);
    chk("t6_model_a0", q[0].addr, 32'hFFFF_FFF0);
    chk("t6_model_l0", q[0].len, 0);
    chk("t6_model_a1", q[1].addr, 32'h0000_0000);
    chk("t6_model_l1", q[1].len, 0);
    wait_q("t6_bursts");
    chk("t6_resp_irq", dma_irq, 0);
    reset_n = 1'b0;
    tick();
    chk("t6_rst_ready", cfg_dma_ready, 1);
    chk("t6_rst_irq", dma_irq, 0);
    chk("t6_rst_err", dma_err, 0);
    chk("t6_rst_axvalid", axvalid, 0);
    reset_n = 1'b1;
    tick();
    send_b(8'h02, 2'b00);
    chk("t6_late_resp_err", dma_err, 4'b0100);
    chk("t6_late_resp_idle", cfg_dma_ready, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
